udt_state_arbiter: RTL and testbench
====================================

# udt_state_arbiter

Parametrised shared-state register with arbitrated multi-writer input and multi-reader broadcast output. It holds the UDT connection state word. Several control engines (listen, peer-close processing, user close, and future keep-alive or timeout engines) propose new state values. Several consumers receive each committed update through independent valid/ready channels. Relative to the fixed 3-writer/1-reader mutex it replaces, it adds selectable arbitration, configurable reader count, optional write blocking until all readers acknowledge, per-reader overrun flags and a commit counter.

## Interface
Parameters:
- WR_NUM, 3, number of writer channels (1..16)
- RD_NUM, 2, number of reader channels (1..8)
- WIDTH, 32, state word width
- ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- BLOCKING, 0, 1 = writes stall while any reader has an unacknowledged update
- RESET_VALUE, 0, value_o after reset

Ports:
- core_clk  in  1  clock; all state changes on rising edge
- core_rst  in  1  reset, asynchronous, active-high
- value_i  in  WR_NUM*WIDTH  proposed values; writer i occupies bits [i*WIDTH +: WIDTH]
- valid_i  in  WR_NUM  writer i request
- ready_o  out  WR_NUM  writer i grant; combinational, one-hot or zero
- value_o  out  WIDTH  current committed state, registered
- valid_o  out  RD_NUM  reader j has an unacknowledged update
- ready_i  in  RD_NUM  reader j accepts
- overrun_o  out  RD_NUM  sticky: reader j missed at least one update
- commit_cnt_o  out  16  number of commits, wraps modulo 2^16

## Operation
- Eligibility: `can_write = (BLOCKING==0) || (pending == 0)`, where pending is the valid_o vector.
- Grant: if can_write, exactly one requesting writer receives ready_o. Otherwise every ready_o is 0.
- Fixed priority (ARB_MODE=0): the lowest requesting index wins.
- Round-robin (ARB_MODE=1): `ptr` is a log2(WR_NUM)-bit register, reset to 0. The search starts at `ptr` and wraps modulo WR_NUM; the first requester found wins. After a commit by writer k, `ptr <= (k+1) mod WR_NUM`. `ptr` is unchanged when there is no commit.
- Commit: occurs when `valid_i[k] & ready_o[k]`.
  - value_o <= writer k slice
  - valid_o <= all ones
  - commit_cnt_o increments
- Commits are unconditional on content. Writing the same value still commits and re-notifies all readers.
- Reader j clears its valid_o bit on `valid_o[j] & ready_i[j]`. If a commit occurs in the same cycle, the set wins and valid_o[j] stays 1.
- Overrun (non-blocking mode only): a commit while valid_o[j]=1 and ready_i[j]=0 sets overrun_o[j]. Readers see only the newest value. overrun_o clears only on reset.
- In BLOCKING=1, overrun_o stays 0 by construction.
- Writers must hold valid_i and value_i stable until granted. A request dropped before grant is not committed.

## Timing
- Reset (async assert, sync-safe deassert by the system): value_o=RESET_VALUE, valid_o=0, overrun_o=0, commit_cnt_o=0, ptr=0.
- While core_rst=1, ready_o=0.
- Grant latency: 0 cycles. ready_o is asserted in the same cycle as valid_i when eligible.
- Commit to value_o/valid_o: 1 cycle.
- Throughput:
  - non-blocking: 1 commit per cycle
  - blocking: 1 commit per (slowest reader acknowledge + 1) cycles
- Reader acknowledge takes effect on the next edge. In blocking mode the earliest next grant is the cycle after the last acknowledge.
- Reset asserted mid-handshake: a pending commit is discarded, and outputs take reset values immediately.
- commit_cnt_o wraps from 0xFFFF to 0x0000 without a flag.

## Test plan
- Reset/idle: assert core_rst, drive valid_i=3'b111 -> ready_o=0, value_o=0, valid_o=0. Release -> first grant on the next cycle (fixed priority: writer 0).
- Fixed priority, WR_NUM=3: valid_i=3'b110 with values 0x11/0x22/0x33 -> writer 1 granted. value_o=0x22 one cycle later, valid_o=2'b11, commit_cnt_o=1.
- Round-robin, all writers requesting continuously for 6 cycles -> grant order 0,1,2,0,1,2, and value_o follows each writer's value.
- Non-blocking overrun: reader 1 holds ready_i=0, reader 0 holds ready_i=1, two commits (0x5 then 0x7) -> value_o=0x7, overrun_o=2'b10, valid_o[1]=1.
- Blocking: commit 0x9, reader 0 acknowledges at cycle +1, reader 1 at cycle +4, writer 2 requests throughout -> ready_o[2]=0 until the cycle after reader 1 acknowledges, then granted. overrun_o stays 0.
- Simultaneous acknowledge and commit: reader asserts ready_i in the same cycle a new commit is granted -> valid_o stays 1 with the new value. commit_cnt_o wraps from 0xFFFF to 0 after 65536 commits.

Source files
------------

// File: rtl/udt_state_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : udt_state_arbiter
//  Description : Shared UDT connection-state register. Several writers
//                propose new state words through an arbitrated valid/ready
//                port; every committed word is broadcast to several readers,
//                each with its own valid/ready channel and sticky overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
module udt_state_arbiter #(
    parameter int               WR_NUM      = 3,
    parameter int               RD_NUM      = 2,
    parameter int               WIDTH       = 32,
    parameter int               ARB_MODE    = 0,
    parameter int               BLOCKING    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    core_clk,
    input  logic                    core_rst,
    input  logic [WR_NUM*WIDTH-1:0] value_i,
    input  logic [WR_NUM-1:0]       valid_i,
    output logic [WR_NUM-1:0]       ready_o,
    output logic [WIDTH-1:0]        value_o,
    output logic [RD_NUM-1:0]       valid_o,
    input  logic [RD_NUM-1:0]       ready_i,
    output logic [RD_NUM-1:0]       overrun_o,
    output logic [15:0]             commit_cnt_o
);

    // A single writer still needs a one-bit pointer/index field
    localparam int PTR_W = (WR_NUM > 1) ? $clog2(WR_NUM) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W-1:0]  winner;
    logic              found;
    logic              can_write;
    logic [WR_NUM-1:0] grant;
    logic              commit;
    logic [WIDTH-1:0]  win_value;
    logic [RD_NUM-1:0] overrun_set;

    // In blocking mode a new word may only be written once every reader has
    // consumed the previous one
    always_comb begin
        can_write = (BLOCKING == 0) || (valid_o == '0);
    end

    // Pick the winning requester: lowest index, or first at/after ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        grant  = '0;
        for (int n = 0; n < WR_NUM; n++) begin
            int idx;
            idx = n;
            if (ARB_MODE == 1) begin
                idx = int'(ptr) + n;
                if (idx >= WR_NUM) begin
                    idx = idx - WR_NUM;
                end
            end
            if (!found && valid_i[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        // No grant is ever visible while reset is held
        if (found && can_write && !core_rst) begin
            grant[winner] = 1'b1;
        end
    end

    // Grant outputs, commit strobe, granted word and round-robin successor
    always_comb begin
        ready_o   = grant;
        commit    = |grant;
        win_value = '0;
        for (int k = 0; k < WR_NUM; k++) begin
            win_value = win_value | (value_i[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
        end
        if (int'(winner) == WR_NUM - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + 1'b1;
        end
    end

    // A reader misses an update when a new word lands on an unconsumed one
    always_comb begin
        overrun_set = '0;
        if (BLOCKING == 0 && commit) begin
            overrun_set = valid_o & ~ready_i;
        end
    end

    // State word, commit counter and round-robin pointer
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            value_o      <= RESET_VALUE;
            commit_cnt_o <= '0;
            ptr          <= '0;
        end else if (commit) begin
            value_o      <= win_value;
            commit_cnt_o <= commit_cnt_o + 16'd1;
            if (ARB_MODE == 1) begin
                ptr <= next_ptr;
            end
        end
    end

    // Per-reader notify and sticky overrun; a commit outranks a same-cycle ack
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            valid_o   <= '0;
            overrun_o <= '0;
        end else begin
            valid_o   <= commit ? {RD_NUM{1'b1}} : (valid_o & ~ready_i);
            overrun_o <= overrun_o | overrun_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udt_state_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_udt_state_arbiter
//  Description : Self-checking bench for udt_state_arbiter. Three instances
//                (fixed priority, round-robin, blocking) share one stimulus
//                stream and are each tracked by a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_udt_state_arbiter;

    localparam logic [31:0] RV_BL = 32'h0000A5A5;

    typedef struct {
        int        ptr;
        logic [31:0] val;
        bit [1:0]  pend;
        bit [1:0]  ovr;
        int        cnt;
    } mdl_t;

    typedef struct {
        logic [2:0]  req;
        logic [1:0]  rdy;
        logic [2:0]  exp_grant;
        logic [31:0] exp_val;
        logic [1:0]  exp_valid;
        logic [1:0]  exp_ovr;
        logic [15:0] exp_cnt;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [95:0] value_i;
    logic [2:0]  valid_i;
    logic [1:0]  ready_i;

    logic [2:0]  rdy_fp, rdy_rr, rdy_bl;
    logic [31:0] val_fp, val_rr, val_bl;
    logic [1:0]  vld_fp, vld_rr, vld_bl;
    logic [1:0]  ovr_fp, ovr_rr, ovr_bl;
    logic [15:0] cnt_fp, cnt_rr, cnt_bl;

    int   vec  = 0;
    int   errs = 0;
    mdl_t m_fp, m_rr, m_bl;
    row_t tbl [8];
    int   order [6];

    always #5 clk = ~clk;

    udt_state_arbiter #(.WR_NUM(3), .RD_NUM(2), .WIDTH(32), .ARB_MODE(0), .BLOCKING(0),
                        .RESET_VALUE(32'h0)) dut_fp (
        .core_clk(clk), .core_rst(rst), .value_i(value_i), .valid_i(valid_i),
        .ready_o(rdy_fp), .value_o(val_fp), .valid_o(vld_fp), .ready_i(ready_i),
        .overrun_o(ovr_fp), .commit_cnt_o(cnt_fp));

    udt_state_arbiter #(.WR_NUM(3), .RD_NUM(2), .WIDTH(32), .ARB_MODE(1), .BLOCKING(0),
                        .RESET_VALUE(32'h0)) dut_rr (
        .core_clk(clk), .core_rst(rst), .value_i(value_i), .valid_i(valid_i),
        .ready_o(rdy_rr), .value_o(val_rr), .valid_o(vld_rr), .ready_i(ready_i),
        .overrun_o(ovr_rr), .commit_cnt_o(cnt_rr));

    udt_state_arbiter #(.WR_NUM(3), .RD_NUM(2), .WIDTH(32), .ARB_MODE(0), .BLOCKING(1),
                        .RESET_VALUE(RV_BL)) dut_bl (
        .core_clk(clk), .core_rst(rst), .value_i(value_i), .valid_i(valid_i),
        .ready_o(rdy_bl), .value_o(val_bl), .valid_o(vld_bl), .ready_i(ready_i),
        .overrun_o(ovr_bl), .commit_cnt_o(cnt_bl));

    // ---------------- behavioural model ----------------
    function automatic mdl_t reset_model(input logic [31:0] rv);
        mdl_t m;
        m.ptr = 0; m.val = rv; m.pend = 2'b00; m.ovr = 2'b00; m.cnt = 0;
        return m;
    endfunction

    // Winning writer index, or -1 when nobody is granted
    function automatic int winner(input mdl_t m, input bit rr, input bit blk, input logic [2:0] req);
        if (blk && (m.pend != 2'b00)) return -1;
        for (int n = 0; n < 3; n++) begin
            int k;
            k = rr ? (m.ptr + n) % 3 : n;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int w);
        if (w < 0) return 3'b000;
        return 3'(1 << w);
    endfunction

    function automatic mdl_t advance(input mdl_t m, input bit rr, input bit blk,
                                     input logic [2:0] req, input logic [95:0] vals,
                                     input logic [1:0] rdy);
        mdl_t n;
        int   w;
        n = m;
        w = winner(m, rr, blk, req);
        for (int j = 0; j < 2; j++) if (m.pend[j] && rdy[j]) n.pend[j] = 1'b0;
        if (w >= 0) begin
            n.val = vals[w*32 +: 32];
            for (int j = 0; j < 2; j++) begin
                if (!blk && m.pend[j] && !rdy[j]) n.ovr[j] = 1'b1;
                n.pend[j] = 1'b1;
            end
            n.cnt = (m.cnt + 1) % 65536;
            if (rr) n.ptr = (w + 1) % 3;
        end
        return n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check("fp value", val_fp, m_fp.val);
        check("fp valid", 32'(vld_fp), 32'(m_fp.pend));
        check("fp overrun", 32'(ovr_fp), 32'(m_fp.ovr));
        check("fp count", 32'(cnt_fp), 32'(m_fp.cnt));
        check("rr value", val_rr, m_rr.val);
        check("rr valid", 32'(vld_rr), 32'(m_rr.pend));
        check("rr overrun", 32'(ovr_rr), 32'(m_rr.ovr));
        check("rr count", 32'(cnt_rr), 32'(m_rr.cnt));
        check("bl value", val_bl, m_bl.val);
        check("bl valid", 32'(vld_bl), 32'(m_bl.pend));
        check("bl overrun", 32'(ovr_bl), 32'(m_bl.ovr));
        check("bl count", 32'(cnt_bl), 32'(m_bl.cnt));
    endtask

    // Apply inputs away from the edge and check the combinational grants
    task automatic drive(input logic [2:0] v, input logic [1:0] r, input logic [95:0] vals);
        valid_i = v; ready_i = r; value_i = vals;
        #1;
        check("fp grant", 32'(rdy_fp), 32'(onehot(winner(m_fp, 1'b0, 1'b0, v))));
        check("rr grant", 32'(rdy_rr), 32'(onehot(winner(m_rr, 1'b1, 1'b0, v))));
        check("bl grant", 32'(rdy_bl), 32'(onehot(winner(m_bl, 1'b0, 1'b1, v))));
    endtask

    // Take one rising edge, advance the models and compare registered state
    task automatic clock_edge();
        @(posedge clk);
        m_fp = advance(m_fp, 1'b0, 1'b0, valid_i, value_i, ready_i);
        m_rr = advance(m_rr, 1'b1, 1'b0, valid_i, value_i, ready_i);
        m_bl = advance(m_bl, 1'b0, 1'b1, valid_i, value_i, ready_i);
        #1;
        check_state();
    endtask

    // Asynchronous reset from wherever the bench currently is
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_fp = reset_model(32'h0);
        m_rr = reset_model(32'h0);
        m_bl = reset_model(RV_BL);
        check("reset fp grant", 32'(rdy_fp), 32'h0);
        check("reset rr grant", 32'(rdy_rr), 32'h0);
        check("reset bl grant", 32'(rdy_bl), 32'h0);
        check("reset fp value", val_fp, 32'h0);
        check("reset bl value", val_bl, RV_BL);
        check_state();
        @(posedge clk);
        #1;
        check("reset hold fp grant", 32'(rdy_fp), 32'h0);
        check_state();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'b110, 2'b00, 3'b010, 32'h22, 2'b11, 2'b00, 16'd1};
        tbl[1] = '{3'b000, 2'b01, 3'b000, 32'h22, 2'b10, 2'b00, 16'd1};
        tbl[2] = '{3'b100, 2'b00, 3'b100, 32'h33, 2'b11, 2'b10, 16'd2};
        tbl[3] = '{3'b011, 2'b11, 3'b001, 32'h11, 2'b11, 2'b10, 16'd3};
        tbl[4] = '{3'b000, 2'b11, 3'b000, 32'h11, 2'b00, 2'b10, 16'd3};
        tbl[5] = '{3'b001, 2'b00, 3'b001, 32'h11, 2'b11, 2'b10, 16'd4};
        tbl[6] = '{3'b000, 2'b10, 3'b000, 32'h11, 2'b01, 2'b10, 16'd4};
        tbl[7] = '{3'b101, 2'b00, 3'b001, 32'h11, 2'b11, 2'b11, 16'd5};
        order  = '{0, 1, 2, 0, 1, 2};

        valid_i = 3'b111; ready_i = 2'b00;
        value_i = {32'h33, 32'h22, 32'h11};
        #2;
        do_reset();

        // First grant right after reset release goes to writer 0
        drive(3'b111, 2'b00, {32'h33, 32'h22, 32'h11});
        check("post-reset first grant", 32'(rdy_fp), 32'h1);
        clock_edge();

        // Table of fixed-priority vectors from a clean reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].req, tbl[i].rdy, {32'h33, 32'h22, 32'h11});
            check("tbl grant", 32'(rdy_fp), 32'(tbl[i].exp_grant));
            clock_edge();
            check("tbl value", val_fp, tbl[i].exp_val);
            check("tbl valid", 32'(vld_fp), 32'(tbl[i].exp_valid));
            check("tbl overrun", 32'(ovr_fp), 32'(tbl[i].exp_ovr));
            check("tbl count", 32'(cnt_fp), 32'(tbl[i].exp_cnt));
        end

        // Round-robin rotation with all writers requesting
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 2'b11, {32'hA2, 32'hA1, 32'hA0});
            check("rr order grant", 32'(rdy_rr), 32'(3'b001 << order[i]));
            clock_edge();
            check("rr order value", val_rr, 32'hA0 + 32'(order[i]));
        end

        // Non-blocking overrun: reader 1 never acknowledges
        do_reset();
        drive(3'b001, 2'b01, {32'h0, 32'h0, 32'h5});
        clock_edge();
        drive(3'b001, 2'b01, {32'h0, 32'h0, 32'h7});
        clock_edge();
        check("overrun value", val_fp, 32'h7);
        check("overrun flags", 32'(ovr_fp), 32'h2);
        check("overrun reader1 valid", 32'(vld_fp[1]), 32'h1);

        // Blocking: writer 2 waits until the cycle after the last acknowledge
        do_reset();
        drive(3'b001, 2'b00, {32'h2B, 32'h0, 32'h9});
        check("block first grant", 32'(rdy_bl), 32'h1);
        clock_edge();
        check("block committed", val_bl, 32'h9);
        drive(3'b100, 2'b01, {32'h2B, 32'h0, 32'h9});
        check("block stall c1", 32'(rdy_bl), 32'h0);
        clock_edge();
        drive(3'b100, 2'b00, {32'h2B, 32'h0, 32'h9});
        check("block stall c2", 32'(rdy_bl), 32'h0);
        clock_edge();
        drive(3'b100, 2'b00, {32'h2B, 32'h0, 32'h9});
        check("block stall c3", 32'(rdy_bl), 32'h0);
        clock_edge();
        drive(3'b100, 2'b10, {32'h2B, 32'h0, 32'h9});
        check("block stall c4", 32'(rdy_bl), 32'h0);
        clock_edge();
        check("block all acked", 32'(vld_bl), 32'h0);
        drive(3'b100, 2'b00, {32'h2B, 32'h0, 32'h9});
        check("block released grant", 32'(rdy_bl), 32'h4);
        clock_edge();
        check("block second value", val_bl, 32'h2B);
        check("block no overrun", 32'(ovr_bl), 32'h0);

        // Acknowledge and commit in the same cycle: the set wins
        drive(3'b001, 2'b00, {32'h0, 32'h0, 32'h40});
        clock_edge();
        drive(3'b010, 2'b11, {32'h0, 32'h41, 32'h0});
        check("ack+commit grant", 32'(rdy_fp), 32'h2);
        clock_edge();
        check("ack+commit valid", 32'(vld_fp), 32'h3);
        check("ack+commit value", val_fp, 32'h41);

        // Reset asserted while a grant is showing discards the commit
        drive(3'b001, 2'b00, {32'h0, 32'h0, 32'h77});
        do_reset();

        // Randomised traffic, with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            drive(3'($urandom), 2'($urandom),
                  {$urandom(), $urandom(), $urandom()});
            clock_edge();
        end

        // Commit counter wrap
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(3'b001, 2'b11, {32'h0, 32'h0, $urandom()});
            clock_edge();
        end
        check("count at max", 32'(cnt_fp), 32'hFFFF);
        drive(3'b001, 2'b11, {32'h0, 32'h0, 32'h1234});
        clock_edge();
        check("count wrapped", 32'(cnt_fp), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
